// File: rtl/dc_ipu_filter_pkg.sv
// Shared types and default widths for the bicubic filter scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dc_ipu_filter_pkg;

    localparam int DEF_DIM_WIDTH        = 12;
    localparam int DEF_STEP_FRACT_WIDTH = 12;
    localparam int DEF_PHASE_WIDTH      = 4;

    // Accumulator carries a sign bit on top of integer + fraction so the
    // half-pixel centre offset can go negative at the left/top edge.
    function automatic int acc_width(input int dim_w, input int fract_w);
        return dim_w + fract_w + 1;
    endfunction

    // Window corner is floor(pos)-1, which can reach -1 (or lower when
    // upscaling), hence one extra sign bit over the destination dimension.
    function automatic int src_width(input int dim_w);
        return dim_w + 1;
    endfunction

    localparam int DEF_STEP_WIDTH = DEF_DIM_WIDTH + DEF_STEP_FRACT_WIDTH;
    localparam int DEF_ACC_WIDTH  = acc_width(DEF_DIM_WIDTH, DEF_STEP_FRACT_WIDTH);
    localparam int DEF_SRC_WIDTH  = src_width(DEF_DIM_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dc_ipu_filter_sched_if.sv
// Request bus from the scheduler to the texel-fetch/weight stage.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the slave stalls the master with all fields held.
interface dc_ipu_filter_sched_if
    import dc_ipu_filter_pkg::*;
#(
    parameter int DIM_WIDTH   = DEF_DIM_WIDTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
);

    logic                   out_valid;
    logic                   out_ready;
    logic [DIM_WIDTH:0]     out_src_x;
    logic [DIM_WIDTH:0]     out_src_y;
    logic [PHASE_WIDTH-1:0] out_phase_x;
    logic [PHASE_WIDTH-1:0] out_phase_y;
    logic                   out_sof;
    logic                   out_eof;
    logic                   out_sol;
    logic                   out_eol;

    modport master (
        output out_valid, out_src_x, out_src_y, out_phase_x, out_phase_y,
        output out_sof, out_eof, out_sol, out_eol,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_src_x, out_src_y, out_phase_x, out_phase_y,
        input  out_sof, out_eof, out_sol, out_eol,
        output out_ready
    );

endinterface

// File: rtl/dc_ipu_filter_sched_axis.sv
// One scan axis: position counter, fixed-point source accumulator, window/phase derivation.
// Latency: derived fields are registered, valid the cycle after a load/restart/advance.
// Backpressure: fields only change on a control strobe, so they hold while the caller stalls.
module dc_ipu_filter_sched_axis
    import dc_ipu_filter_pkg::*;
#(
    parameter int DIM_WIDTH        = DEF_DIM_WIDTH,
    parameter int STEP_FRACT_WIDTH = DEF_STEP_FRACT_WIDTH,
    parameter int PHASE_WIDTH      = DEF_PHASE_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  nreset,
    input  logic                                  load_i,
    input  logic                                  restart_i,
    input  logic                                  advance_i,
    input  logic [DIM_WIDTH-1:0]                  size_i,
    input  logic [DIM_WIDTH+STEP_FRACT_WIDTH-1:0] step_i,
    output logic                                  first_o,
    output logic                                  last_o,
    output logic [DIM_WIDTH:0]                    src_o,
    output logic [PHASE_WIDTH-1:0]                phase_o
);

    localparam int STEP_W = DIM_WIDTH + STEP_FRACT_WIDTH;
    localparam int ACC_W  = acc_width(DIM_WIDTH, STEP_FRACT_WIDTH);
    localparam int SRC_W  = src_width(DIM_WIDTH);

    // Half a source pixel: subtracted from step/2 to align pixel centres.
    localparam logic [ACC_W-1:0] HALF_PIX =
        {{(ACC_W-STEP_FRACT_WIDTH){1'b0}}, 1'b1, {(STEP_FRACT_WIDTH-1){1'b0}}};
    localparam logic [DIM_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [SRC_W-1:0]     SRC_ONE = 1;

    logic [DIM_WIDTH-1:0]   size_q, size_d;
    logic [DIM_WIDTH-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [ACC_W-1:0]       init_q, init_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic [SRC_W-1:0]       src_q, src_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                   upd;

    // Next counter/accumulator values and the request fields they imply.
    always_comb begin
        upd    = load_i | restart_i | advance_i;
        size_d = size_q;
        step_d = step_q;
        init_d = init_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        if (load_i) begin
            size_d = size_i;
            step_d = step_i;
            init_d = {2'b00, step_i[STEP_W-1:1]} - HALF_PIX;
            cnt_d  = '0;
            acc_d  = init_d;
        end else if (restart_i) begin
            cnt_d = '0;
            acc_d = init_q;
        end else if (advance_i) begin
            cnt_d = cnt_q + CNT_ONE;
            acc_d = acc_q + {1'b0, step_q};
        end
        first_d = (cnt_d == '0);
        last_d  = (size_d != '0) && (cnt_d == size_d - CNT_ONE);
        // Integer bits of the accumulator are floor(pos) in two's complement,
        // so slicing them is the arithmetic shift truncated to SRC_W bits.
        src_d   = acc_d[STEP_FRACT_WIDTH +: SRC_W] - SRC_ONE;
        phase_d = acc_d[STEP_FRACT_WIDTH-1 -: PHASE_WIDTH];
    end

    // Axis state; output fields move only on a strobe so stalls hold them.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            size_q  <= '0;
            step_q  <= '0;
            init_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            src_q   <= '0;
            phase_q <= '0;
        end else begin
            size_q <= size_d;
            step_q <= step_d;
            init_q <= init_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            if (upd) begin
                first_q <= first_d;
                last_q  <= last_d;
                src_q   <= src_d;
                phase_q <= phase_d;
            end
        end
    end

    assign first_o = first_q;
    assign last_o  = last_q;
    assign src_o   = src_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/dc_ipu_filter_sched.sv
// Per-frame raster scheduler issuing one 4x4 window request per destination pixel.
// Latency: first request valid one cycle after start; one request per clock when unstalled.
// Backpressure: valid/ready; all request fields held while out_valid & !out_ready.
module dc_ipu_filter_sched
    import dc_ipu_filter_pkg::*;
#(
    parameter int DIM_WIDTH        = DEF_DIM_WIDTH,
    parameter int STEP_FRACT_WIDTH = DEF_STEP_FRACT_WIDTH,
    parameter int PHASE_WIDTH      = DEF_PHASE_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  nreset,
    input  logic                                  clr,
    input  logic                                  start,
    input  logic [DIM_WIDTH-1:0]                  cfg_dst_width,
    input  logic [DIM_WIDTH-1:0]                  cfg_dst_height,
    input  logic [DIM_WIDTH+STEP_FRACT_WIDTH-1:0] cfg_step_x,
    input  logic [DIM_WIDTH+STEP_FRACT_WIDTH-1:0] cfg_step_y,
    output logic                                  busy,
    output logic                                  done,
    dc_ipu_filter_sched_if.master                 out_if
);

    sched_state_e state_q, state_d;
    logic         load;
    logic         adv_x, rst_x, adv_y;
    logic         x_first, x_last, y_first, y_last;
    logic         fire;

    assign fire = out_if.out_valid & out_if.out_ready;

    // Frame state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: clr wins, start only from IDLE, each fire steps the raster.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv_x   = 1'b0;
        rst_x   = 1'b0;
        adv_y   = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        load = 1'b1;
                        // Empty frame: report completion without issuing anything.
                        if (cfg_dst_width == '0 || cfg_dst_height == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (x_last) begin
                            if (y_last) begin
                                state_d = ST_DONE;
                            end else begin
                                rst_x = 1'b1;
                                adv_y = 1'b1;
                            end
                        end else begin
                            adv_x = 1'b1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    dc_ipu_filter_sched_axis #(
        .DIM_WIDTH        (DIM_WIDTH),
        .STEP_FRACT_WIDTH (STEP_FRACT_WIDTH),
        .PHASE_WIDTH      (PHASE_WIDTH)
    ) u_axis_x (
        .clk       (clk),
        .nreset    (nreset),
        .load_i    (load),
        .restart_i (rst_x),
        .advance_i (adv_x),
        .size_i    (cfg_dst_width),
        .step_i    (cfg_step_x),
        .first_o   (x_first),
        .last_o    (x_last),
        .src_o     (out_if.out_src_x),
        .phase_o   (out_if.out_phase_x)
    );

    dc_ipu_filter_sched_axis #(
        .DIM_WIDTH        (DIM_WIDTH),
        .STEP_FRACT_WIDTH (STEP_FRACT_WIDTH),
        .PHASE_WIDTH      (PHASE_WIDTH)
    ) u_axis_y (
        .clk       (clk),
        .nreset    (nreset),
        .load_i    (load),
        .restart_i (1'b0),
        .advance_i (adv_y),
        .size_i    (cfg_dst_height),
        .step_i    (cfg_step_y),
        .first_o   (y_first),
        .last_o    (y_last),
        .src_o     (out_if.out_src_y),
        .phase_o   (out_if.out_phase_y)
    );

    assign out_if.out_valid = (state_q == ST_RUN);
    assign out_if.out_sol   = x_first;
    assign out_if.out_eol   = x_last;
    assign out_if.out_sof   = x_first & y_first;
    assign out_if.out_eof   = x_last & y_last;
    assign done             = (state_q == ST_DONE);
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dc_ipu_filter_sched.sv
module tb_dc_ipu_filter_sched;
    import dc_ipu_filter_pkg::*;

    localparam int DW    = DEF_DIM_WIDTH;
    localparam int SW    = DEF_SRC_WIDTH;
    localparam int PW    = DEF_PHASE_WIDTH;
    localparam int STW   = DEF_STEP_WIDTH;
    localparam int OBS_W = 1 + 2*SW + 2*PW + 4;

    logic           clk    = 1'b0;
    logic           nreset = 1'b1;
    logic           clr    = 1'b0;
    logic           start  = 1'b0;
    logic [DW-1:0]  cfg_w  = '0;
    logic [DW-1:0]  cfg_h  = '0;
    logic [STW-1:0] cfg_sx = '0;
    logic [STW-1:0] cfg_sy = '0;
    logic           busy;
    logic           done;
    int             n_checks = 0;
    int             n_fail   = 0;

    dc_ipu_filter_sched_if #(.DIM_WIDTH(DW), .PHASE_WIDTH(PW)) out_if ();

    dc_ipu_filter_sched #(
        .DIM_WIDTH        (DW),
        .STEP_FRACT_WIDTH (DEF_STEP_FRACT_WIDTH),
        .PHASE_WIDTH      (PW)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .clr            (clr),
        .start          (start),
        .cfg_dst_width  (cfg_w),
        .cfg_dst_height (cfg_h),
        .cfg_step_x     (cfg_sx),
        .cfg_step_y     (cfg_sy),
        .busy           (busy),
        .done           (done),
        .out_if         (out_if)
    );

    always #5 clk = ~clk;

    logic [OBS_W-1:0] obs;
    assign obs = {out_if.out_valid, out_if.out_src_x, out_if.out_src_y,
                  out_if.out_phase_x, out_if.out_phase_y,
                  out_if.out_sof, out_if.out_eof, out_if.out_sol, out_if.out_eol};

    // Packs a valid request with the given hand-computed fields.
    function automatic logic [OBS_W-1:0] req(input int sx, input int sy, input int px, input int py,
                                             input logic sof, input logic eof,
                                             input logic sol, input logic eol);
        logic [SW-1:0] sxv;
        logic [SW-1:0] syv;
        logic [PW-1:0] pxv;
        logic [PW-1:0] pyv;
        sxv = SW'(sx);
        syv = SW'(sy);
        pxv = PW'(px);
        pyv = PW'(py);
        return {1'b1, sxv, syv, pxv, pyv, sof, eof, sol, eol};
    endfunction

    // Unity-scale 4x2 frame: src_x = col-1, src_y = row-1, zero phases.
    function automatic logic [OBS_W-1:0] unity_req(input int k);
        return req(k % 4 - 1, k / 4 - 1, 0, 0, k == 0, k == 7, k % 4 == 0, k % 4 == 3);
    endfunction

    // Present a start pulse for one clock; returns on the following negedge.
    task automatic kick(input int w, input int h, input int sx, input int sy);
        cfg_w  = DW'(w);
        cfg_h  = DW'(h);
        cfg_sx = STW'(sx);
        cfg_sy = STW'(sy);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset;
        out_if.out_ready = 1'b0;
        #2 nreset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, obs} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b req=%h want all 0", busy, done, obs);
        end
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_if.out_valid, done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset got v/d/b=%b want 000", {out_if.out_valid, done, busy});
        end
    endtask

    task automatic test_unity;
        out_if.out_ready = 1'b1;
        kick(4, 2, 4096, 4096);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (obs !== unity_req(k)) begin
                n_fail++;
                $display("FAIL unity_req%0d got %h want %h", k, obs, unity_req(k));
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_if.out_valid, done, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL unity_done got v/d/b=%b want 011", {out_if.out_valid, done, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({out_if.out_valid, done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL unity_idle got v/d/b=%b want 000", {out_if.out_valid, done, busy});
        end
    endtask

    task automatic test_scaled(input string name, input int w, input int sx,
                               input logic [OBS_W-1:0] exp_q[$]);
        out_if.out_ready = 1'b1;
        kick(w, 1, sx, 4096);
        foreach (exp_q[k]) begin
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s_req%0d got %h want %h", name, k, obs, exp_q[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_if.out_valid, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_done got v/d=%b want 01", name, {out_if.out_valid, done});
        end
        @(negedge clk);
    endtask

    task automatic test_downscale;
        logic [OBS_W-1:0] e[$];
        e.push_back(req(-1, -1, 8, 0, 1'b1, 1'b0, 1'b1, 1'b0));
        e.push_back(req( 1, -1, 8, 0, 1'b0, 1'b1, 1'b0, 1'b1));
        test_scaled("down", 2, 8192, e);
    endtask

    task automatic test_upscale;
        logic [OBS_W-1:0] e[$];
        e.push_back(req(-2, -1, 12, 0, 1'b1, 1'b0, 1'b1, 1'b0));
        e.push_back(req(-1, -1,  4, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        e.push_back(req(-1, -1, 12, 0, 1'b0, 1'b1, 1'b0, 1'b1));
        test_scaled("up", 3, 2048, e);
    endtask

    task automatic test_backpressure;
        int               k = 0;
        bit               stalled = 1'b0;
        bit               saw_done = 1'b0;
        logic [OBS_W-1:0] held = '0;
        out_if.out_ready = 1'b0;
        kick(4, 2, 4096, 4096);
        // Config changes during the frame must not leak into it.
        cfg_w  = DW'(2);
        cfg_sx = STW'(8192);
        for (int cyc = 0; cyc < 200 && !saw_done; cyc++) begin
            if (done) begin
                saw_done = 1'b1;
            end else if (out_if.out_valid) begin
                if (stalled) begin
                    n_checks++;
                    if (obs !== held) begin
                        n_fail++;
                        $display("FAIL bp_hold req%0d got %h want %h", k, obs, held);
                    end
                end
                out_if.out_ready = 1'($urandom_range(0, 1));
                if (out_if.out_ready) begin
                    n_checks++;
                    if (k >= 8 || obs !== unity_req(k)) begin
                        n_fail++;
                        $display("FAIL bp_req%0d got %h want %h", k, obs, unity_req(k));
                    end
                    k++;
                    stalled = 1'b0;
                end else begin
                    held    = obs;
                    stalled = 1'b1;
                end
            end
            if (!saw_done) @(negedge clk);
        end
        n_checks++;
        if (!saw_done || k != 8) begin
            n_fail++;
            $display("FAIL bp_count got %0d requests done=%0d want 8 done=1", k, saw_done);
        end
        out_if.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_dim;
        for (int i = 0; i < 2; i++) begin
            kick((i == 0) ? 0 : 3, (i == 0) ? 2 : 0, 4096, 4096);
            n_checks++;
            if ({out_if.out_valid, done, busy} !== 3'b011) begin
                n_fail++;
                $display("FAIL zero%0d_done got v/d/b=%b want 011", i, {out_if.out_valid, done, busy});
            end
            @(negedge clk);
            n_checks++;
            if ({out_if.out_valid, done, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL zero%0d_idle got v/d/b=%b want 000", i, {out_if.out_valid, done, busy});
            end
        end
    endtask

    task automatic test_clr;
        out_if.out_ready = 1'b1;
        kick(4, 2, 4096, 4096);
        repeat (3) @(negedge clk);
        out_if.out_ready = 1'b0;
        n_checks++;
        if (obs !== unity_req(3)) begin
            n_fail++;
            $display("FAIL clr_req3 got %h want %h", obs, unity_req(3));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (obs !== unity_req(3)) begin
            n_fail++;
            $display("FAIL clr_start_ignored got %h want %h", obs, unity_req(3));
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if ({out_if.out_valid, done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL clr_abort got v/d/b=%b want 000", {out_if.out_valid, done, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({out_if.out_valid, done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL clr_no_done got v/d/b=%b want 000", {out_if.out_valid, done, busy});
        end
        out_if.out_ready = 1'b1;
        kick(4, 2, 4096, 4096);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (obs !== unity_req(k)) begin
                n_fail++;
                $display("FAIL clr_restart_req%0d got %h want %h", k, obs, unity_req(k));
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_restart_done got %b want 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unity();
        test_downscale();
        test_upscale();
        test_backpressure();
        test_zero_dim();
        test_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
